// File: rtl/frame_reader_if.sv
// rtl/frame_reader_if.sv - pixel stream handshake bundle between frame_reader and its consumer
interface frame_reader_if #(
  parameter int V = 8
) ();
  logic [V-1:0] px_data;
  logic         px_valid;
  logic         px_ready;
  logic         px_eol;
  logic         px_eof;

  modport master (output px_data, px_valid, px_eol, px_eof, input px_ready);
  modport slave  (input px_data, px_valid, px_eol, px_eof, output px_ready);
endinterface

// File: rtl/frame_reader.sv
// rtl/frame_reader.sv - reads one raster frame from single-port pixel RAM into a valid/ready pixel stream
module frame_reader #(
  parameter int V = 8,
  parameter int W = 320,
  parameter int H = 240,
  parameter int A = 20
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  output logic           ram_we_o,
  output logic [A-1:0]   ram_addr_o,
  input  logic [V-1:0]   ram_data_i,
  frame_reader_if.master px,
  output logic           busy_o,
  output logic           done_o
);

  localparam int XW = (W > 1) ? $clog2(W) : 1;
  localparam int YW = (H > 1) ? $clog2(H) : 1;
  localparam logic [A-1:0]  LAST_ADDR = A'(W * H - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(W - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(H - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_e;

  state_e         state_q, state_d;
  logic [A-1:0]   rd_cnt_q, rd_cnt_d;
  logic [A-1:0]   addr_q, addr_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic           inf_q, inf_d;
  logic           inf_eol_q, inf_eol_d;
  logic           inf_eof_q, inf_eof_d;
  logic [V-1:0]   buf_data_q [2];
  logic [V-1:0]   buf_data_d [2];
  logic [1:0]     buf_eol_q, buf_eol_d;
  logic [1:0]     buf_eof_q, buf_eof_d;
  logic           head_q, head_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           done_q, done_d;

  logic           issue;
  logic           pop;
  logic           wr_idx;
  logic [2:0]     occ;

  assign pop    = (cnt_q != 2'd0) && px.px_ready;
  assign wr_idx = head_q ^ cnt_q[0];
  assign occ    = {1'b0, cnt_q} + {2'b00, inf_q};

  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    addr_d     = addr_q;
    x_d        = x_q;
    y_d        = y_q;
    inf_d      = 1'b0;
    inf_eol_d  = inf_eol_q;
    inf_eof_d  = inf_eof_q;
    buf_data_d = buf_data_q;
    buf_eol_d  = buf_eol_q;
    buf_eof_d  = buf_eof_q;
    done_d     = 1'b0;
    issue      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_ISSUE;
          rd_cnt_d = '0;
          x_d      = '0;
          y_d      = '0;
        end
      end
      // A pop this cycle frees a slot, so the credit check counts it in advance.
      S_ISSUE: issue = (occ < (3'd2 + {2'b00, pop}));
      S_DRAIN: begin
        if (pop && (cnt_q == 2'd1) && !inf_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      addr_d    = rd_cnt_q;
      inf_d     = 1'b1;
      inf_eol_d = (x_q == X_LAST);
      inf_eof_d = (rd_cnt_q == LAST_ADDR);
      if (rd_cnt_q == LAST_ADDR) begin
        state_d = S_DRAIN;
      end else begin
        rd_cnt_d = rd_cnt_q + A'(1);
      end
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q != Y_LAST) y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    // RAM word for the previous cycle's address lands behind any entry still queued.
    if (inf_q) begin
      buf_data_d[wr_idx] = ram_data_i;
      buf_eol_d[wr_idx]  = inf_eol_q;
      buf_eof_d[wr_idx]  = inf_eof_q;
    end

    cnt_d  = cnt_q + {1'b0, inf_q} - {1'b0, pop};
    head_d = head_q ^ pop;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      rd_cnt_q      <= '0;
      addr_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      inf_q         <= 1'b0;
      inf_eol_q     <= 1'b0;
      inf_eof_q     <= 1'b0;
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_eol_q     <= '0;
      buf_eof_q     <= '0;
      head_q        <= 1'b0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      addr_q     <= addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      inf_q      <= inf_d;
      inf_eol_q  <= inf_eol_d;
      inf_eof_q  <= inf_eof_d;
      buf_data_q <= buf_data_d;
      buf_eol_q  <= buf_eol_d;
      buf_eof_q  <= buf_eof_d;
      head_q     <= head_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

  // The address being read shows combinationally; otherwise the last issued one is held.
  assign ram_addr_o  = issue ? rd_cnt_q : addr_q;
  assign ram_we_o    = 1'b0;
  assign px.px_valid = (cnt_q != 2'd0);
  assign px.px_data  = buf_data_q[head_q];
  assign px.px_eol   = px.px_valid & buf_eol_q[head_q];
  assign px.px_eof   = px.px_valid & buf_eof_q[head_q];
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;

endmodule

// File: tb/tb_frame_reader.sv
// tb/tb_frame_reader.sv - directed self-checking bench for frame_reader (4x3 frame plus full-size frame)
module tb_frame_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic        we1, we2, busy1, busy2, done1, done2;
  logic [19:0] addr1, addr2;
  logic [7:0]  rdata1, rdata2;

  frame_reader_if #(.V(8)) px1 ();
  frame_reader_if #(.V(8)) px2 ();

  frame_reader #(.V(8), .W(4), .H(3), .A(20)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .ram_we_o(we1), .ram_addr_o(addr1),
    .ram_data_i(rdata1), .px(px1), .busy_o(busy1), .done_o(done1)
  );

  frame_reader dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .ram_we_o(we2), .ram_addr_o(addr2),
    .ram_data_i(rdata2), .px(px2), .busy_o(busy2), .done_o(done2)
  );

  always #5 clk = ~clk;

  // RAM models: mem[i] = i + 8'h10, one-cycle read latency.
  always @(posedge clk) begin
    rdata1 <= addr1[7:0] + 8'h10;
    rdata2 <= addr2[7:0] + 8'h10;
  end

  int checks = 0;
  int failures = 0;

  logic [7:0] q_data[$];
  logic       q_eol[$];
  logic       q_eof[$];
  int done_cnt, stall_bad, max_out, timed_out;

  task automatic pulse_start1();
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  // Runs from the current negedge until done1 is seen, recording accepted pixels.
  task automatic collect(input int pct, input int max_cyc, input int start_at);
    logic rdy, prev_stall;
    logic [7:0] pd;
    logic pe, pf;
    int acc;
    q_data.delete(); q_eol.delete(); q_eof.delete();
    done_cnt = 0; stall_bad = 0; max_out = 0; timed_out = 1; acc = 0;
    prev_stall = 1'b0; pd = '0; pe = 1'b0; pf = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      if (done1) begin
        done_cnt++;
        timed_out = 0;
        break;
      end
      if (prev_stall && (!px1.px_valid || px1.px_data !== pd || px1.px_eol !== pe || px1.px_eof !== pf))
        stall_bad++;
      start1 = (c == start_at);
      rdy = ($urandom_range(0, 99) < pct);
      px1.px_ready = rdy;
      #1;
      if (px1.px_valid && rdy) begin
        q_data.push_back(px1.px_data);
        q_eol.push_back(px1.px_eol);
        q_eof.push_back(px1.px_eof);
        acc++;
      end
      if (busy1 && (int'(addr1) + 1 - acc) > max_out) max_out = int'(addr1) + 1 - acc;
      prev_stall = px1.px_valid && !rdy;
      pd = px1.px_data; pe = px1.px_eol; pf = px1.px_eof;
      @(negedge clk);
    end
  endtask

  task automatic check_sequence(input string name);
    logic [7:0] e;
    checks++;
    if (timed_out != 0 || q_data.size() != 12) begin
      failures++;
      $display("FAIL %s_count got=%0d exp=12 timeout=%0d", name, q_data.size(), timed_out);
    end
    for (int i = 0; i < q_data.size() && i < 12; i++) begin
      e = 8'h10 + 8'(i);
      checks++;
      if ({q_data[i], q_eol[i], q_eof[i]} !== {e, (i % 4) == 3, i == 11}) begin
        failures++;
        $display("FAIL %s_px%0d got=%h/%b/%b exp=%h/%b/%b", name, i, q_data[i], q_eol[i], q_eof[i],
                 e, (i % 4) == 3, i == 11);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    px1.px_ready = 1'b0;
    px2.px_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy1, done1, px1.px_valid, px1.px_eol, px1.px_eof, px1.px_data, addr1, we1} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b/%b/%b/%b/%b/%h/%h/%b exp=all0", busy1, done1, px1.px_valid,
               px1.px_eol, px1.px_eof, px1.px_data, addr1, we1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy1, px1.px_valid, busy2, px2.px_valid, addr2} !== '0) begin
      failures++;
      $display("FAIL reset_release got=%b/%b/%b/%b/%h exp=0", busy1, px1.px_valid, busy2, px2.px_valid, addr2);
    end
  endtask

  task automatic test_full_frame();
    logic [7:0] e;
    px1.px_ready = 1'b1;
    pulse_start1();
    checks++;
    if (addr1 !== 20'd0 || busy1 !== 1'b1) begin
      failures++;
      $display("FAIL ff_t0 got addr=%h busy=%b exp addr=0 busy=1", addr1, busy1);
    end
    for (int t = 1; t <= 15; t++) begin
      @(negedge clk);
      if (t == 1) begin
        checks++;
        if (px1.px_valid !== 1'b0) begin
          failures++;
          $display("FAIL ff_early_valid got=%b exp=0", px1.px_valid);
        end
      end else if (t <= 13) begin
        e = 8'h10 + 8'(t - 2);
        checks++;
        if ({px1.px_valid, px1.px_data, px1.px_eol, px1.px_eof, done1} !==
            {1'b1, e, ((t - 2) % 4) == 3, t == 13, 1'b0}) begin
          failures++;
          $display("FAIL ff_px%0d got=%b/%h/%b/%b/%b exp=1/%h/%b/%b/0", t - 2, px1.px_valid, px1.px_data,
                   px1.px_eol, px1.px_eof, done1, e, ((t - 2) % 4) == 3, t == 13);
        end
      end else if (t == 14) begin
        checks++;
        if ({done1, busy1, px1.px_valid} !== 3'b100) begin
          failures++;
          $display("FAIL ff_done got done/busy/valid=%b%b%b exp=100", done1, busy1, px1.px_valid);
        end
      end else begin
        checks++;
        if ({done1, busy1} !== 2'b00) begin
          failures++;
          $display("FAIL ff_done_pulse got done/busy=%b%b exp=00", done1, busy1);
        end
      end
    end
  endtask

  task automatic test_random_ready();
    pulse_start1();
    collect(50, 300, -1);
    check_sequence("rand");
    checks++;
    if (stall_bad != 0 || max_out > 2 || done_cnt != 1) begin
      failures++;
      $display("FAIL rand_handshake got stall_bad=%0d max_out=%0d done=%0d exp 0/<=2/1", stall_bad, max_out, done_cnt);
    end
  endtask

  task automatic test_stall();
    int max_addr = 0;
    px1.px_ready = 1'b0;
    pulse_start1();
    for (int t = 0; t < 10; t++) begin
      if (int'(addr1) > max_addr) max_addr = int'(addr1);
      @(negedge clk);
    end
    checks++;
    if (addr1 !== 20'd1 || max_addr != 1 || px1.px_valid !== 1'b1 || px1.px_data !== 8'h10) begin
      failures++;
      $display("FAIL stall_hold got addr=%h max=%0d valid=%b data=%h exp addr=1 max=1 valid=1 data=10",
               addr1, max_addr, px1.px_valid, px1.px_data);
    end
    collect(100, 100, -1);
    check_sequence("stall");
  endtask

  task automatic test_restart();
    px1.px_ready = 1'b1;
    pulse_start1();
    collect(100, 100, 5);
    check_sequence("midstart");
    checks++;
    if (done_cnt != 1 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL midstart_done got done=%0d busy=%b exp 1/0", done_cnt, busy1);
    end
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checks++;
    if (addr1 !== 20'd0 || busy1 !== 1'b1) begin
      failures++;
      $display("FAIL restart_addr got addr=%h busy=%b exp 0/1", addr1, busy1);
    end
    collect(100, 100, -1);
    check_sequence("restart");
  endtask

  task automatic test_async_reset();
    int found = 0;
    px1.px_ready = 1'b1;
    pulse_start1();
    for (int t = 0; t < 20; t++) begin
      if (px1.px_valid && px1.px_data == 8'h15) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (found == 0) begin
      failures++;
      $display("FAIL arst_wait got=no_pixel5 exp=pixel5");
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy1, done1, px1.px_valid, px1.px_eol, px1.px_eof, px1.px_data, addr1} !== '0) begin
      failures++;
      $display("FAIL arst_outputs got=%b/%b/%b/%b/%b/%h/%h exp=all0", busy1, done1, px1.px_valid,
               px1.px_eol, px1.px_eof, px1.px_data, addr1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start1();
    checks++;
    if (addr1 !== 20'd0) begin
      failures++;
      $display("FAIL arst_restart_addr got=%h exp=0", addr1);
    end
    collect(100, 100, -1);
    check_sequence("arst");
  endtask

  task automatic test_full_size();
    int n = 0, eol_n = 0, eof_n = 0, bad = 0, max_addr = 0, done_t = -1;
    logic [7:0] e;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int t = 0; t < 80000; t++) begin
      if (done2) begin
        done_t = t;
        break;
      end
      if (int'(addr2) > max_addr) max_addr = int'(addr2);
      if (px2.px_valid) begin
        e = 8'(n) + 8'h10;
        if (px2.px_data !== e || (px2.px_eof && n != 76799)) bad++;
        eol_n += int'(px2.px_eol);
        eof_n += int'(px2.px_eof);
        n++;
      end
      @(negedge clk);
    end
    checks++;
    if (n != 76800 || bad != 0) begin
      failures++;
      $display("FAIL big_pixels got n=%0d bad=%0d exp n=76800 bad=0", n, bad);
    end
    checks++;
    if (eol_n != 240 || eof_n != 1) begin
      failures++;
      $display("FAIL big_markers got eol=%0d eof=%0d exp eol=240 eof=1", eol_n, eof_n);
    end
    checks++;
    if (max_addr != 76799 || done_t != 76802) begin
      failures++;
      $display("FAIL big_timing got max_addr=%0d done_t=%0d exp 76799/76802", max_addr, done_t);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_random_ready();
    test_stall();
    test_restart();
    test_async_reset();
    test_full_size();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
